// File: rtl/fir_avg_pkg.sv
// ============================================================================
//  Module   : fir_avg_pkg
//  Brief    : Shared constants, level type and rounding helper for the FIR
//             averaging output stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_avg_pkg;

  localparam int FIR_W      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int RND        = 2;

  typedef logic [$clog2(FIFO_DEPTH):0] level_t;

  // (s + 2) >>> 2 at FIR_W+3 bits, keeping the low FIR_W bits of the quotient
  function automatic logic signed [FIR_W-1:0] round_div4(input logic signed [FIR_W+1:0] s);
    logic [FIR_W+2:0] w_sum;
    w_sum = {s[FIR_W+1], s} + (FIR_W+3)'(RND);
    return w_sum[FIR_W+1:2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_avg_fifo.sv
// ============================================================================
//  Module   : fir_avg_fifo
//  Brief    : Small synchronous FIFO; pointers and occupancy reset, storage not.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_avg_fifo #(
  parameter int w     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [w-1:0]             i_wdata,
  output logic [w-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int c_ADDR_W = $clog2(DEPTH);

  logic [w-1:0]        r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wptr;
  logic [c_ADDR_W-1:0] r_rptr;
  logic [c_ADDR_W:0]   r_level;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + c_ADDR_W'(1);
      if (i_pop)  r_rptr <= r_rptr + c_ADDR_W'(1);
      if (i_push && !i_pop)
        r_level <= r_level + (c_ADDR_W+1)'(1);
      else if (!i_push && i_pop)
        r_level <= r_level - (c_ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == (c_ADDR_W+1)'(DEPTH));
  assign o_level = r_level;
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

endmodule

`default_nettype wire

// File: rtl/fir_avg_out_stage.sv
// ============================================================================
//  Module   : fir_avg_out_stage
//  Brief    : Rounds the 4-tap FIR running sum to an average, drops warm-up
//             samples, buffers results behind valid/ready, flags overflow.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_avg_out_stage
  import fir_avg_pkg::*;
#(
  parameter int w      = 16,
  parameter int DEPTH  = 4,
  parameter int WARMUP = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [w+1:0]      s,
  input  logic                     s_valid,
  output logic signed [w-1:0]      avg,
  output logic                     avg_valid,
  input  logic                     avg_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     clr_ovf
);

  // Sized so WARMUP itself is representable, including WARMUP = 0
  localparam int c_WCNT_W = $clog2(WARMUP + 2);

  logic [c_WCNT_W-1:0] r_warm_cnt;
  logic                r_ovf;
  logic                w_warm_done;
  logic                w_push_req;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;
  logic                w_full;
  logic                w_empty;
  logic [w-1:0]        w_rdata;
  logic signed [w-1:0] w_avg_in;

  assign w_warm_done = (r_warm_cnt == c_WCNT_W'(WARMUP));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_warm_cnt <= '0;
    else if (s_valid && !w_warm_done)
      r_warm_cnt <= r_warm_cnt + c_WCNT_W'(1);
  end

  if (w == FIR_W) begin : g_pkg_round
    assign w_avg_in = round_div4(s);
  end else begin : g_generic_round
    logic [w+2:0] w_sum;
    assign w_sum    = {s[w+1], s} + (w+3)'(RND);
    assign w_avg_in = w_sum[w+1:2];
  end

  // A full FIFO still accepts a push when the head leaves on the same edge
  assign w_pop      = !w_empty && avg_ready;
  assign w_push_req = s_valid && w_warm_done;
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_push     = w_push_req && !w_drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ovf <= 1'b0;
    else if (w_drop)
      r_ovf <= 1'b1;
    else if (clr_ovf)
      r_ovf <= 1'b0;
  end

  fir_avg_fifo #(
    .w     (w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_avg_in),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign avg       = w_rdata;
  assign avg_valid = !w_empty;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire
